seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed driver for the Basys3 4-digit common-anode 7-segment display.
//   Takes a 16-bit hex value, per-digit decimal points and blank mask; scans an[3:0], decodes each nibble to seg/dp.
//   New data is double-buffered and swapped only at frame end (no tearing).
//   Sits between datapath/switch logic and the board display pins; replaces static single-digit drive.
// PARAMETERS
//   SLOT_CYCLES   100000  clk cycles each digit is selected (1 ms @ 100 MHz); must be >= 2
//   GUARD_CYCLES  500     cycles at start of each slot with all anodes off (anti-ghosting); < SLOT_CYCLES
// PORTS
//   clk         in   1   system clock, 100 MHz
//   reset       in   1   synchronous, active-high
//   load        in   1   one-cycle strobe: capture value/dp_in/blank into pending buffer
//   value       in   16  hex digits; value[3:0] -> digit 0 (an[0], rightmost)
//   dp_in       in   4   decimal point per digit, 1 = lit
//   blank       in   4   per-digit blank, 1 = digit dark (seg and dp off)
//   seg         out  7   segments {g,f,e,d,c,b,a}, active low
//   dp          out  1   decimal point, active low
//   an          out  4   anodes, active low, at most one low at a time
//   busy        out  1   pending buffer holds data not yet displayed
//   frame_done  out  1   one-cycle pulse when digit 3 slot ends (frame wrap)
// BEHAVIOUR
//   Reset (sync, next edge): an=4'b1111, seg=7'b1111111, dp=1, busy=0, frame_done=0;
//     slot counter=0, digit index=0, active and pending buffers cleared (value 0, dp 0, blank 0).
//     Reset mid-frame discards any pending load.
//   Slot counter runs 0..SLOT_CYCLES-1; at SLOT_CYCLES-1 it wraps to 0 and index advances 0->1->2->3->0.
//   Wrap 3->0 = frame end: frame_done=1 that cycle (registered, visible next edge); pending->active if busy.
//   Counter < GUARD_CYCLES: an=4'b1111; otherwise an[index]=0, others 1.
//   seg/dp always reflect the active digit at index; all outputs registered, 1-cycle latency from counter/index.
//   Decode (active low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//     8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
//   blank[i]=1: seg=7'b1111111, dp=1 during digit i slot; anode still scanned.
//   load: no ready; always accepted. Sets busy=1; later load in same frame overwrites pending (last wins).
//   load in the frame-end cycle: data bypasses to active for new frame; busy stays 0.
//   busy clears on the edge where pending is transferred.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digit i (i=3..1) also dark if its nibble and all higher nibbles are 0;
//     digit 0 never suppressed; its dp remains controlled by dp_in.
//   Not defined: every digit shows its nibble, zeros displayed as '0'; only blank[] darkens digits.
// TESTING  (bench uses SLOT_CYCLES=8, GUARD_CYCLES=2)
//   Reset held 3 cycles -> an=1111, seg=1111111, dp=1, busy=0, frame_done=0 throughout.
//   Free run after reset -> an cycles 1110,1101,1011,0111, each low 6 cycles with 2 cycles 1111 between;
//     frame_done pulses every 32 cycles; seg=1000000 (all zeros).
//   load value=16'h12AF, dp_in=0, blank=0 mid-frame -> busy=1, display unchanged until frame_done;
//     next frame digit0..3 seg = 0001110, 0001000, 0100100, 1111001; busy=0.
//   Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 displayed; load on frame-end cycle
//     (16'h3333) -> shown in immediately following frame, busy never asserted.
//   blank=4'b0100, dp_in=4'b0001 -> digit2 seg=1111111 dp=1; digit0 dp=0; reset mid-frame with busy=1
//     -> busy=0, display returns to zeros.
//   value=16'h0070: with LEADING_ZERO_BLANK_EN digits 3,2 dark, digit1=1111000, digit0=1000000;
//     without macro digits 3,2 show 1000000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for a 4-digit common-anode 7-segment
//                display. A 16-bit hex value, per-digit decimal points and a
//                blank mask are double-buffered. The pending copy moves to the
//                displayed copy only at frame end, so a frame never mixes old
//                and new data. Each digit slot starts with a short guard
//                window with all anodes off to stop ghosting.
//  Ports       : clk        - system clock
//                reset      - synchronous, active-high
//                load       - one-cycle strobe, captures value/dp_in/blank
//                value      - four hex digits, value[3:0] is digit 0 (an[0])
//                dp_in      - decimal point per digit, 1 = lit
//                blank      - per-digit blank, 1 = digit dark
//                seg        - segments {g,f,e,d,c,b,a}, active low
//                dp         - decimal point, active low
//                an         - anodes, active low, at most one low
//                busy       - pending buffer holds data not yet displayed
//                frame_done - one-cycle pulse when the digit 3 slot ends
//  Options     : LEADING_ZERO_BLANK_EN - when defined, digits 3..1 also go
//                dark when their nibble and every higher nibble are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy,
    output logic        frame_done
);

    localparam int          CNT_W     = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GUARD     = CNT_W'(GUARD_CYCLES);

    // Scan position
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;

    // Displayed and pending buffers
    logic [15:0] r_act_value;
    logic [3:0]  r_act_dp;
    logic [3:0]  r_act_blank;
    logic [15:0] r_pend_value;
    logic [3:0]  r_pend_dp;
    logic [3:0]  r_pend_blank;
    logic        r_busy;

    // Registered outputs
    logic [6:0]  r_seg;
    logic        r_dp;
    logic [3:0]  r_an;
    logic        r_frame_done;

    logic        w_slot_end;
    logic        w_frame_end;
    logic [3:0]  w_nib;
    logic        w_dark;
    logic [6:0]  w_dec;
    logic [3:0]  w_an;

    assign w_slot_end  = (r_cnt == c_SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);

    // ------------------------------------------------------------------
    // Digit selection and decode
    // ------------------------------------------------------------------
    always_comb begin
        w_nib  = r_act_value[{r_idx, 2'b00} +: 4];
        w_dark = r_act_blank[r_idx];
`ifdef LEADING_ZERO_BLANK_EN
        // Shifting out the lower digits leaves this nibble and all higher
        // ones; zero means this digit is a leading zero. Digit 0 is exempt.
        if ((r_idx != 2'd0) && ((r_act_value >> {r_idx, 2'b00}) == 16'd0)) begin
            w_dark = 1'b1;
        end
`endif
    end

    always_comb begin
        w_dec = 7'b1111111;
        case (w_nib)
            4'h0: w_dec = 7'b1000000;
            4'h1: w_dec = 7'b1111001;
            4'h2: w_dec = 7'b0100100;
            4'h3: w_dec = 7'b0110000;
            4'h4: w_dec = 7'b0011001;
            4'h5: w_dec = 7'b0010010;
            4'h6: w_dec = 7'b0000010;
            4'h7: w_dec = 7'b1111000;
            4'h8: w_dec = 7'b0000000;
            4'h9: w_dec = 7'b0010000;
            4'hA: w_dec = 7'b0001000;
            4'hB: w_dec = 7'b0000011;
            4'hC: w_dec = 7'b1000110;
            4'hD: w_dec = 7'b0100001;
            4'hE: w_dec = 7'b0000110;
            4'hF: w_dec = 7'b0001110;
            default: w_dec = 7'b1111111;
        endcase
    end

    always_comb begin
        w_an = 4'b1111;
        if (r_cnt >= c_GUARD) begin
            w_an[r_idx] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. A load landing on the frame-end cycle goes straight
    // to the displayed copy so it appears in the very next frame without
    // ever raising busy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_value  <= 16'd0;
            r_act_dp     <= 4'd0;
            r_act_blank  <= 4'd0;
            r_pend_value <= 16'd0;
            r_pend_dp    <= 4'd0;
            r_pend_blank <= 4'd0;
            r_busy       <= 1'b0;
        end else if (w_frame_end) begin
            if (load) begin
                r_act_value <= value;
                r_act_dp    <= dp_in;
                r_act_blank <= blank;
            end else if (r_busy) begin
                r_act_value <= r_pend_value;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
            end
            r_busy <= 1'b0;
        end else if (load) begin
            r_pend_value <= value;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank;
            r_busy       <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: one cycle behind the scan position
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an         <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_dark ? 7'b1111111 : w_dec;
            r_dp         <= w_dark ? 1'b1 : ~r_act_dp[r_idx];
            r_frame_done <= w_frame_end;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
